// File: rtl/serial_word_packer.sv
// Serial-to-parallel word packer: collects DW framed serial bits into a word
// and offers it to a downstream FIFO through a single holding register.
module serial_word_packer #(
    parameter int DW        = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk_1,
    input  logic          rst,
    input  logic          ser_in,
    input  logic          ser_valid,
    input  logic          ser_start,
    input  logic          buffer_full,
    output logic [DW-1:0] data_1,
    output logic          data_1_en,
    output logic          busy,
    output logic          err_overrun,
    output logic          err_abort,
    output logic [7:0]    words_out
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [DW-1:0]   shift_reg, shift_next;
    logic [DW-1:0]   hold_reg, hold_next;
    logic            hold_valid_reg, hold_valid_next;
    logic            overrun_reg, overrun_next;
    logic            abort_reg, abort_next;
    logic [7:0]      words_reg, words_next;

    logic [DW-1:0]   shift_ins;
    logic [DW-1:0]   first_ins;
    logic            drain;
    logic            word_done;

    // Bit order only changes where a new bit enters the shift register.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_ins = {shift_reg[DW-2:0], ser_in};
            assign first_ins = {{(DW-1){1'b0}}, ser_in};
        end else begin : g_lsb_first
            assign shift_ins = {ser_in, shift_reg[DW-1:1]};
            assign first_ins = {ser_in, {(DW-1){1'b0}}};
        end
    endgenerate

    assign drain = hold_valid_reg & ~buffer_full;

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        overrun_next    = overrun_reg;
        abort_next      = abort_reg;
        words_next      = words_reg;
        word_done       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ser_valid && ser_start) begin
                    shift_next   = first_ins;
                    bit_cnt_next = CW'(1);
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_valid) begin
                    if (ser_start) begin
                        abort_next   = 1'b1;
                        shift_next   = first_ins;
                        bit_cnt_next = CW'(1);
                    end else begin
                        shift_next   = shift_ins;
                        bit_cnt_next = bit_cnt_reg + CW'(1);
                        if (bit_cnt_reg == CW'(DW - 1)) begin
                            word_done    = 1'b1;
                            bit_cnt_next = '0;
                            state_next   = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (drain) begin
            hold_valid_next = 1'b0;
            words_next      = words_reg + 8'd1;
        end

        // A word finishing on a drain edge may reuse the slot being emptied.
        if (word_done) begin
            if (!hold_valid_reg || drain) begin
                hold_next       = shift_ins;
                hold_valid_next = 1'b1;
            end else begin
                overrun_next    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            abort_reg      <= 1'b0;
            words_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            overrun_reg    <= overrun_next;
            abort_reg      <= abort_next;
            words_reg      <= words_next;
        end
    end

    assign data_1      = hold_reg;
    assign data_1_en   = drain;
    assign busy        = (state_reg == SHIFT);
    assign err_overrun = overrun_reg;
    assign err_abort   = abort_reg;
    assign words_out   = words_reg;

endmodule

// File: tb/tb_serial_word_packer.sv
// Bench for serial_word_packer: MSB-first and LSB-first instances share one
// input stream and are compared every cycle against a bit-list reference model.
module tb_serial_word_packer;

    logic        clk_1 = 1'b0;
    logic        rst = 1'b0;
    logic        ser_in = 1'b0;
    logic        ser_valid = 1'b0;
    logic        ser_start = 1'b0;
    logic        buffer_full = 1'b0;

    logic [15:0] data_msb, data_lsb;
    logic        en_msb, en_lsb, busy_msb, busy_lsb;
    logic        ovr_msb, ovr_lsb, abt_msb, abt_lsb;
    logic [7:0]  words_msb, words_lsb;

    int tests_run = 0;
    int tests_failed = 0;

    serial_word_packer #(.DW(16), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk_1(clk_1), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
        .ser_start(ser_start), .buffer_full(buffer_full), .data_1(data_msb),
        .data_1_en(en_msb), .busy(busy_msb), .err_overrun(ovr_msb),
        .err_abort(abt_msb), .words_out(words_msb)
    );

    serial_word_packer #(.DW(16), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk_1(clk_1), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
        .ser_start(ser_start), .buffer_full(buffer_full), .data_1(data_lsb),
        .data_1_en(en_lsb), .busy(busy_lsb), .err_overrun(ovr_lsb),
        .err_abort(abt_lsb), .words_out(words_lsb)
    );

    always #5 clk_1 = ~clk_1;

    // Reference model: the word under construction is just a list of bits.
    bit          m_known = 1'b0;
    bit          m_busy;
    bit          m_bits[$];
    logic [15:0] m_hold_msb, m_hold_lsb;
    bit          m_hv, m_ovr, m_abt;
    int          m_words;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic exp_en;
        exp_en = m_hv && !buffer_full;
        check_val("data_msb",  32'(data_msb),  32'(m_hold_msb));
        check_val("data_lsb",  32'(data_lsb),  32'(m_hold_lsb));
        check_val("en_msb",    32'(en_msb),    32'(exp_en));
        check_val("en_lsb",    32'(en_lsb),    32'(exp_en));
        check_val("busy_msb",  32'(busy_msb),  32'(m_busy));
        check_val("busy_lsb",  32'(busy_lsb),  32'(m_busy));
        check_val("overrun",   32'(ovr_msb),   32'(m_ovr));
        check_val("abort",     32'(abt_lsb),   32'(m_abt));
        check_val("words_msb", 32'(words_msb), 32'(m_words));
        check_val("words_lsb", 32'(words_lsb), 32'(m_words));
    endtask

    task automatic model_step();
        bit          drain, done, hv_old;
        logic [15:0] w_msb, w_lsb;
        if (rst) begin
            m_busy = 0; m_bits.delete();
            m_hold_msb = '0; m_hold_lsb = '0;
            m_hv = 0; m_ovr = 0; m_abt = 0; m_words = 0; m_known = 1;
        end else begin
            hv_old = m_hv;
            drain  = m_hv && !buffer_full;
            done   = 0;
            w_msb  = '0;
            w_lsb  = '0;
            if (ser_valid) begin
                if (ser_start) begin
                    if (m_busy) m_abt = 1;
                    m_bits.delete();
                    m_bits.push_back(bit'(ser_in));
                    m_busy = 1;
                end else if (m_busy) begin
                    m_bits.push_back(bit'(ser_in));
                    if (m_bits.size() == 16) begin
                        done = 1;
                        for (int i = 0; i < 16; i++) begin
                            if (m_bits[i]) begin
                                w_msb = w_msb + (16'd1 << (15 - i));
                                w_lsb = w_lsb + (16'd1 << i);
                            end
                        end
                        m_busy = 0;
                        m_bits.delete();
                    end
                end
            end
            if (drain) begin
                m_words = (m_words + 1) % 256;
                m_hv = 0;
            end
            if (done) begin
                if (!hv_old || drain) begin
                    m_hold_msb = w_msb; m_hold_lsb = w_lsb; m_hv = 1;
                end else begin
                    m_ovr = 1;
                end
            end
        end
    endtask

    // One clock cycle: drive, check combinational view, step model at the edge.
    task automatic tick(input bit r, input bit v, input bit s, input bit d, input bit bf);
        rst = r; ser_valid = v; ser_start = s; ser_in = d; buffer_full = bf;
        #1;
        if (m_known) check_outputs();
        @(posedge clk_1);
        model_step();
        @(negedge clk_1);
    endtask

    task automatic send_word(input logic [15:0] w, input bit msb_first, input bit bf);
        for (int i = 0; i < 16; i++)
            tick(0, 1, i == 0, msb_first ? w[15 - i] : w[i], bf);
    endtask

    task automatic idle(input int n, input bit bf);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, bf);
    endtask

    initial begin
        @(negedge clk_1);
        tick(1, 1, 1, 1, 0);
        tick(1, 0, 0, 0, 0);
        check_val("rst_data", 32'(data_msb), 32'h0);
        check_val("rst_en",   32'(en_msb),   32'h0);
        check_val("rst_busy", 32'(busy_msb), 32'h0);
        check_val("rst_flags", 32'({ovr_msb, abt_msb}), 32'h0);
        check_val("rst_words", 32'(words_msb), 32'h0);

        send_word(16'hA5C3, 1, 0);
        check_val("a5c3_data", 32'(data_msb), 32'hA5C3);
        check_val("a5c3_en",   32'(en_msb),   32'h1);
        idle(1, 0);
        check_val("a5c3_en_off", 32'(en_msb), 32'h0);
        check_val("a5c3_words",  32'(words_msb), 32'h1);

        send_word(16'h1234, 0, 0);
        check_val("lsb_1234", 32'(data_lsb), 32'h1234);
        idle(2, 0);

        send_word(16'hBEEF, 1, 1);
        idle(5, 1);
        check_val("full_hold_en", 32'(en_msb), 32'h0);
        send_word(16'h0001, 1, 1);
        check_val("ovr_flag", 32'(ovr_msb), 32'h1);
        check_val("ovr_data", 32'(data_msb), 32'hBEEF);
        tick(0, 0, 0, 0, 0);
        check_val("beef_drained_en", 32'(en_msb), 32'h0);
        idle(2, 0);

        for (int i = 0; i < 7; i++) tick(0, 1, i == 0, 1, 0);
        send_word(16'h00FF, 1, 0);
        check_val("abort_flag", 32'(abt_msb), 32'h1);
        check_val("abort_data", 32'(data_msb), 32'h00FF);
        idle(2, 0);

        for (int i = 0; i < 10; i++) tick(0, 1, i == 0, 1, 0);
        tick(1, 1, 0, 1, 0);
        check_val("midrst_busy",  32'(busy_msb), 32'h0);
        check_val("midrst_en",    32'(en_msb),   32'h0);
        check_val("midrst_flags", 32'({ovr_msb, abt_msb}), 32'h0);
        send_word(16'h3C5A, 1, 0);
        check_val("midrst_data", 32'(data_msb), 32'h3C5A);
        idle(1, 0);

        tick(1, 0, 0, 0, 0);
        for (int w = 0; w < 256; w++) send_word(16'($urandom), 1, 0);
        idle(1, 0);
        check_val("b2b_wrap",    32'(words_msb), 32'h0);
        check_val("b2b_overrun", 32'(ovr_msb), 32'h0);

        for (int c = 0; c < 3000; c++) begin
            tick(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0),
                 1'($urandom),
                 ($urandom_range(0, 9) < 3));
        end
        idle(2, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
